// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 keyboard MMIO reader: register map, receiver
// states and status/data register field positions.
package kbd_pkg;

    localparam logic [31:0] KBD_DATA_ADDR = 32'h1004F100;
    localparam logic [31:0] KBD_STAT_ADDR = 32'h1004F104;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 4;
    localparam int STAT_OVF_BIT = 7;
    localparam int STAT_ERR_LSB = 8;
    localparam int STAT_ERR_W   = 8;
    localparam int DATA_NE_BIT  = 8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head is visible combinationally, push/pop take effect on the clock edge.
// Push on full is dropped unless a pop happens on the same edge; pop on empty is ignored.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // a simultaneous pop frees the slot, so a full FIFO can still accept
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/kbd_mmio_reader.sv
// PS/2 keyboard receiver feeding a scan-code FIFO, exposed as data (pop) and status MMIO registers.
// Reads are combinational; the keyboard cannot be back-pressured, so a full FIFO drops bytes and flags overflow.
module kbd_mmio_reader
    import kbd_pkg::*;
#(
    parameter logic [31:0] DATA_ADDR = KBD_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR = KBD_STAT_ADDR,
    parameter int          DEPTH     = 8,
    parameter int          TIMEOUT   = 4096
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [31:0] addr,
    input  logic        rd,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        nonempty
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    ps2c_sync_q, ps2c_sync_d;
    logic [1:0]    ps2d_sync_q, ps2d_sync_d;
    logic          sample_q, sample_d;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    err_q, err_d;

    logic          ps2_fall, rx_bit, frame_ok, fifo_push, err_inc;
    logic          hit_data, hit_stat, pop_req, stat_rd, ovf_set;
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty;
    logic [AW:0]   fifo_count;

    assign hit_data = (addr == DATA_ADDR);
    assign hit_stat = (addr == STAT_ADDR);
    assign hit      = hit_data | hit_stat;
    assign pop_req  = rd & hit_data;
    assign stat_rd  = rd & hit_stat;
    assign nonempty = ~fifo_empty;

    // receiver: a bit is consumed the cycle after the synchronized falling edge
    always_comb begin
        ps2c_sync_d = {ps2c_sync_q[1:0], ps2_clk};
        ps2d_sync_d = {ps2d_sync_q[0], ps2_data};
        ps2_fall    = ps2c_sync_q[2] & ~ps2c_sync_q[1];
        rx_bit      = ps2d_sync_q[1];
        sample_d    = ps2_fall;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        frame_ok    = 1'b0;
        fifo_push   = 1'b0;
        err_inc     = 1'b0;
        tmo_d       = (state_q == RX_IDLE || ps2_fall) ? '0 : tmo_q + 1'b1;

        if (sample_q) begin
            case (state_q)
                RX_IDLE: begin
                    if (!rx_bit) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {rx_bit, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_d   = rx_bit;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    frame_ok  = (^{shift_q, par_q}) & rx_bit;
                    fifo_push = frame_ok;
                    err_inc   = ~frame_ok;
                    state_d   = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (state_q != RX_IDLE && tmo_q == TW'(TIMEOUT)) begin
            // stalled frame: drop silently, it is not a line error
            state_d = RX_IDLE;
            tmo_d   = '0;
        end
    end

    // a same-edge set wins over the read-to-clear
    always_comb begin
        ovf_set = fifo_push & fifo_full & ~pop_req;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (stat_rd) begin
            ovf_d = 1'b0;
        end
        if (err_inc) begin
            err_d = sat_inc8(err_q);
        end else if (stat_rd) begin
            err_d = '0;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit_data && !fifo_empty) begin
            rdata[7:0]         = fifo_head;
            rdata[DATA_NE_BIT] = 1'b1;
        end else if (hit_stat) begin
            rdata[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
            rdata[STAT_OVF_BIT]               = ovf_q;
            rdata[STAT_ERR_LSB +: STAT_ERR_W] = err_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps2c_sync_q <= '1;
            ps2d_sync_q <= '1;
            sample_q    <= 1'b0;
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= '0;
        end else begin
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_sync_q <= ps2d_sync_d;
            sample_q    <= sample_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST_N),
        .push     (fifo_push),
        .push_dat (shift_q),
        .pop      (pop_req),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: doc/kbd_mmio_reader.md
KBD_MMIO_READER -- requirements
Module: kbd_mmio_reader

Interface
REQ-001 Parameter DATA_ADDR, 32'h1004F100, memory-mapped keyboard data (pop) register address.
REQ-002 Parameter STAT_ADDR, 32'h1004F104, memory-mapped status register address.
REQ-003 Parameter DEPTH, 8, scan-code FIFO depth in entries (power of two).
REQ-004 Parameter TIMEOUT, 4096, CLK cycles allowed between PS/2 falling edges inside a frame.
REQ-005 CLK  input  1  system clock; all state changes on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to CLK.
REQ-008 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous to CLK.
REQ-009 addr  input  32  CPU data-bus address.
REQ-010 rd  input  1  CPU read strobe, one CLK cycle per access.
REQ-011 rdata  output  32  read data for a decoded address.
REQ-012 hit  output  1  high when addr equals DATA_ADDR or STAT_ADDR.
REQ-013 nonempty  output  1  high when the FIFO holds at least one byte.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a frame bit is sampled on the CLK cycle after a detected falling edge of the synchronized ps2_clk.
REQ-015 Receiver FSM states: IDLE, DATA, PARITY, STOP; IDLE->DATA on a sampled 0 (start bit); a sampled 1 in IDLE is ignored.
REQ-016 DATA SHALL shift in 8 bits LSB first, then move to PARITY; PARITY samples one bit, then STOP; STOP samples one bit, then returns to IDLE.
REQ-017 A frame is valid only if the data bits plus the parity bit contain an odd number of ones and the stop bit is 1.
REQ-018 A valid frame SHALL push its byte into the FIFO on the cycle the stop bit is sampled.
REQ-019 An invalid frame SHALL be discarded, and err_cnt (8-bit, saturating at 8'hFF) SHALL increment.
REQ-020 If the FSM is outside IDLE and TIMEOUT cycles elapse without a ps2_clk falling edge, it SHALL return to IDLE, discard the partial frame, and leave err_cnt unchanged.
REQ-021 A push to a full FIFO SHALL drop the byte and set the sticky overflow flag.
REQ-022 A push and a pop in the same cycle on a full FIFO SHALL both succeed, with no overflow.
REQ-023 A pop on an empty FIFO SHALL be a no-op.
REQ-024 rdata SHALL be combinational from addr and FIFO state, valid in the same cycle as rd; rdata = 0 when hit = 0.
REQ-025 Reading DATA_ADDR SHALL return {23'b0, nonempty, head byte}, or 0 when empty; the pop occurs on the CLK edge ending the rd cycle.
REQ-026 Reading STAT_ADDR SHALL return {16'b0, err_cnt[7:0], overflow, 3'b0, count[3:0]}.
REQ-027 Reading STAT_ADDR with rd = 1 SHALL clear overflow and err_cnt on that edge; a same-edge set takes priority over the clear.
REQ-028 count ranges 0..DEPTH; FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-029 RST_N low SHALL immediately force the FSM to IDLE and clear FIFO pointers, count, overflow, err_cnt, bit counter, timeout counter and synchronizers (synchronizers reset to 1).
REQ-030 During reset, nonempty = 0 and hit/rdata follow addr with an empty FIFO.
REQ-031 A frame in progress when reset is asserted SHALL be lost, with no error counted.

Structure
REQ-032 Package kbd_pkg SHALL hold the address constants, the FSM state enum and the status-field bit positions.
REQ-033 The FIFO SHALL be a separate sub-module, sync_fifo (parameter DEPTH, width 8, push/pop/full/empty/count).

Verification
REQ-034 Send frame 0x1C with good parity; then rd at DATA_ADDR -> rdata = 32'h0000011C, then nonempty = 0.
REQ-035 Send 0x1C with bad parity -> FIFO unchanged; STAT_ADDR read -> err_cnt = 1; a second read -> 0.
REQ-036 Send 9 frames 0x01..0x09 with no reads -> status count = 8, overflow = 1; 8 DATA reads return 0x01..0x08 in order.
REQ-037 With the FIFO full, read DATA_ADDR on the exact stop-bit sample cycle of a new frame -> count stays 8, overflow = 0, new byte stored last.
REQ-038 Stop ps2_clk after 4 data bits for 5000 cycles, then send 0x2A -> only 0x2A is received, err_cnt = 0.
REQ-039 Assert RST_N low mid-frame with 3 bytes queued -> count = 0, nonempty = 0 immediately; the next full frame is received correctly.
